// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a valid/ready FIFO: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Define UART_TX_PARITY_EN to compile in the parity bit (sense chosen by PARITY_ODD).
module uart_tx_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int DIV   = CLK_HZ / BAUD;
  localparam int DIV_W = $clog2(DIV);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int IDX_W = $clog2(DATA_BITS);

  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1 || FIFO_DEPTH != (1 << AW)) begin : g_bad_param
    $error("uart_tx_fifo: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q, count_d;
  logic                 push, pop, load, bit_end, fifo_empty;
  logic [DATA_BITS-1:0] rd_data;

  assign tx_ready   = (count_q != (AW+1)'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign fifo_empty = (count_q == '0);
  assign rd_data    = mem[rd_ptr_q];
  assign bit_end    = (div_q == DIV_W'(DIV - 1));

  // NOTE: the storage array has no reset; clearing the pointers already discards its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= tx_data;
  end

  // NOTE: every default is assigned before the case so no path leaves a variable unassigned (no latch).
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    pop     = 1'b0;
    load    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != S_IDLE) div_d = bit_end ? '0 : div_q + DIV_W'(1);

    unique case (state_q)
      S_IDLE: begin
        div_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        load   = !fifo_empty;
      end
      S_START: if (bit_end) begin
        state_d = S_DATA;
        idx_d   = '0;
        tx_d    = shift_q[0];
      end
      S_DATA: if (bit_end) begin
        if (idx_q == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
          tx_d    = par_q;
`else
          state_d = S_STOP;
          idx_d   = '0;
          tx_d    = 1'b1;
`endif
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) begin
        state_d = S_STOP;
        idx_d   = '0;
        tx_d    = 1'b1;
      end
`endif
      S_STOP: if (bit_end) begin
        if (idx_q == IDX_W'(STOP_BITS - 1)) begin
          // Chain straight into the next start bit when more data is waiting.
          if (fifo_empty) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end else begin
            load = 1'b1;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      pop     = 1'b1;
      state_d = S_START;
      shift_d = rd_data;
      idx_d   = '0;
      div_d   = '0;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_d   = (^rd_data) ^ 1'(PARITY_ODD);
`endif
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

endmodule
